// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the fetch/data unified-memory arbiter
package mem_arbiter_pkg;
  localparam int CMD_XLEN = 32;
  localparam int CMD_ADDR_W = 32;
  typedef enum logic {IDLE, RD_WAIT} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;
  typedef struct packed {
    logic we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_XLEN-1:0] wdata;
    logic [CMD_XLEN/8-1:0] be;
  } mem_cmd_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: fetch/data priority with starvation override and command mux
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  win,
  input  logic                  i_req,
  input  logic [CMD_ADDR_W-1:0] i_addr,
  input  logic                  d_req,
  input  mem_cmd_t              d_cmd,
  input  logic [CNT_W-1:0]      starve_cnt,
  output logic                  pick_i,
  output logic                  pick_d,
  output mem_cmd_t              cmd
);
  always_comb begin
    pick_i = win & i_req & ((starve_cnt == CNT_W'(STARVE_LIMIT)) | ~d_req);
    pick_d = win & d_req & ~pick_i;
    cmd = pick_i ? mem_cmd_t'{we: 1'b0, addr: i_addr, wdata: '0, be: '1} : d_cmd;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports, one transaction at a time
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN = CMD_XLEN,
  parameter int ADDR_W = CMD_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  arb_state_t state, state_n;
  arb_owner_t owner, owner_n;
  logic [CNT_W-1:0] starve_cnt, starve_n;
  logic win, rd_done, pick_i, pick_d;
  mem_cmd_t cmd;
  assign rd_done = reset & (state == RD_WAIT) & mem_rvalid;
  assign win = reset & ((state == IDLE) | mem_rvalid);
  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_pick (
    .win(win),
    .i_req(i_req),
    .i_addr(i_addr),
    .d_req(d_req),
    .d_cmd(mem_cmd_t'{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be}),
    .starve_cnt(starve_cnt),
    .pick_i(pick_i),
    .pick_d(pick_d),
    .cmd(cmd)
  );
  always_comb begin
    mem_req = pick_i | pick_d;
    mem_we = cmd.we;
    mem_addr = cmd.addr;
    mem_wdata = cmd.wdata;
    mem_be = cmd.be;
    i_gnt = pick_i & mem_ready;
    d_gnt = pick_d & mem_ready;
    i_rvalid = rd_done & (owner == OWN_I);
    d_rvalid = rd_done & (owner == OWN_D);
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
    state_n = (i_gnt | d_gnt) ? (cmd.we ? IDLE : RD_WAIT) : (rd_done ? IDLE : state);
    owner_n = ((i_gnt | d_gnt) & ~cmd.we) ? (pick_i ? OWN_I : OWN_D) : owner;
    starve_n = (i_gnt | ~i_req) ? '0 :
               (d_gnt & (starve_cnt != CNT_W'(STARVE_LIMIT))) ? starve_cnt + 1'b1 : starve_cnt;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      owner <= OWN_D;
      starve_cnt <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      starve_cnt <= starve_n;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests with a memory model and a transaction-level reference model
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  typedef struct {int due; logic [31:0] data;} rsp_t;
  logic clk = 0, reset = 0;
  logic i_req = 0;
  logic [31:0] i_addr = 0;
  logic i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic d_req = 0, d_we = 0;
  logic [31:0] d_addr = 0, d_wdata = 0;
  logic [3:0] d_be = 0;
  logic d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic mem_ready = 1, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  int vectors = 0, fails = 0, cyc = 0, lat = 1, stalls = 0, streak = 0;
  bit spur = 0, rv_real = 0;
  bit e_ig, e_dg, e_mreq, e_irv, e_drv, pf;
  logic [31:0] mem [int];
  rsp_t rq[$];
  bit own_q[$];
  string glog = "";
  logic [31:0] ilog[$], dlog[$];

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32), .ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] rd(logic [31:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : a;
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    vectors++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic chk_s(string n, string a, string e);
    vectors++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got '%s' expected '%s'", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    glog = "";
    ilog.delete();
    dlog.delete();
  endtask

  always @(negedge clk) begin
    bit busy, win;
    busy = own_q.size() > 0 && !mem_rvalid;
    win = reset && !busy;
    pf = win && i_req && (streak >= LIMIT || !d_req);
    e_ig = pf && mem_ready;
    e_dg = win && d_req && !pf && mem_ready;
    e_mreq = win && (i_req || d_req);
    e_irv = reset && mem_rvalid && own_q.size() > 0 && own_q[0];
    e_drv = reset && mem_rvalid && own_q.size() > 0 && !own_q[0];
    chk("i_gnt", i_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    chk("mem_req", mem_req, e_mreq);
    chk("i_rvalid", i_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("i_rdata", i_rdata, mem_rdata);
    chk("d_rdata", d_rdata, mem_rdata);
    if (e_mreq) begin
      chk("mem_we", mem_we, pf ? 1'b0 : d_we);
      chk("mem_addr", mem_addr, pf ? i_addr : d_addr);
      chk("mem_wdata", mem_wdata, pf ? 32'h0 : d_wdata);
      chk("mem_be", mem_be, pf ? 4'hF : d_be);
    end
    if (i_gnt) glog = {glog, "I"};
    if (d_gnt) glog = {glog, "D"};
    if (i_rvalid) ilog.push_back(i_rdata);
    if (d_rvalid) dlog.push_back(d_rdata);
    if (mem_req && !mem_ready) stalls++;
  end

  always @(posedge clk) begin
    logic [31:0] w;
    if (!reset) begin
      own_q.delete();
      streak = 0;
    end else begin
      if (mem_rvalid && own_q.size() > 0) void'(own_q.pop_front());
      if (e_ig || (e_dg && !d_we)) own_q.push_back(e_ig);
      streak = (e_ig || !i_req) ? 0 : (e_dg && streak < LIMIT) ? streak + 1 : streak;
    end
    if (rv_real) void'(rq.pop_front());
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        w = rd(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        mem[int'(mem_addr)] = w;
      end else rq.push_back('{cyc + lat, rd(mem_addr)});
    end
    cyc++;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_rvalid <= 1'b1;
      mem_rdata <= rq[0].data;
      rv_real = 1;
    end else begin
      mem_rvalid <= spur;
      mem_rdata <= 32'hBAD00000 ^ cyc;
      rv_real = 0;
    end
  end

  initial begin
    i_req = 1;
    d_req = 1;
    repeat (2) tick();
    chk_s("reset grants", glog, "");
    i_req = 0;
    d_req = 0;
    reset = 1;
    tick();

    clear_logs();
    i_req = 1; i_addr = 0;
    tick();
    i_addr = 4;
    tick();
    i_addr = 8;
    tick();
    i_req = 0;
    repeat (2) tick();
    chk_s("fetch grants", glog, "III");
    chk("fetch rsp count", ilog.size(), 3);
    chk("fetch rsp0", ilog[0], 0);
    chk("fetch rsp1", ilog[1], 4);
    chk("fetch rsp2", ilog[2], 8);
    chk("fetch d rsp count", dlog.size(), 0);

    clear_logs();
    d_req = 1; d_we = 1; d_addr = 100; d_wdata = 25; d_be = 4'hF;
    i_req = 1; i_addr = 12;
    tick();
    d_req = 0; d_we = 0;
    tick();
    i_req = 0;
    repeat (2) tick();
    chk_s("write grants", glog, "DI");
    chk("mem[100]", rd(100), 25);
    chk("write d rsp count", dlog.size(), 0);
    chk("write i rsp count", ilog.size(), 1);
    chk("write i rsp0", ilog[0], 12);

    clear_logs();
    d_req = 1; d_we = 0; d_addr = 200; i_req = 1; i_addr = 300;
    repeat (10) tick();
    d_req = 0; i_req = 0;
    repeat (2) tick();
    chk_s("starve grants", glog, "DDDDIDDDDI");
    chk("starve d rsp count", dlog.size(), 8);
    chk("starve i rsp count", ilog.size(), 2);
    chk("starve i rsp0", ilog[0], 300);
    chk("starve d rsp7", dlog[7], 200);

    clear_logs();
    stalls = 0;
    mem_ready = 0; d_req = 1; d_we = 0; d_addr = 400;
    repeat (3) tick();
    chk_s("stall grants", glog, "");
    chk("stall cycles", stalls, 3);
    mem_ready = 1;
    tick();
    d_req = 0;
    repeat (2) tick();
    chk_s("stall release grants", glog, "D");
    chk("stall d rsp count", dlog.size(), 1);
    chk("stall d rsp0", dlog[0], 400);

    clear_logs();
    lat = 3;
    d_req = 1; d_addr = 500;
    tick();
    d_req = 0;
    tick();
    reset = 0;
    tick();
    reset = 1;
    tick();
    lat = 1;
    i_req = 1; i_addr = 600;
    tick();
    i_req = 0;
    repeat (2) tick();
    chk_s("reset-mid grants", glog, "DI");
    chk("reset-mid d rsp count", dlog.size(), 0);
    chk("reset-mid i rsp count", ilog.size(), 1);
    chk("reset-mid i rsp0", ilog[0], 600);

    clear_logs();
    spur = 1;
    tick();
    spur = 0;
    repeat (2) tick();
    chk("spurious i rsp count", ilog.size(), 0);
    chk("spurious d rsp count", dlog.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
